// File: rtl/my_pipe_pkg.sv
// rtl/my_pipe_pkg.sv - shared helpers for the elastic pipeline register
package my_pipe_pkg;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/my_pipe_stage.sv
// rtl/my_pipe_stage.sv - one valid+data register of the elastic pipeline
module my_pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next state: clear drops the valid bit only; data moves only with a valid source.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = src_valid_i;
      if (src_valid_i) begin
        data_d = src_data_i;
      end
    end
  end

  // Stage register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/my_pipe.sv
// rtl/my_pipe.sv - DEPTH-stage elastic pipeline register with flush and occupancy
module my_pipe
  import my_pipe_pkg::*;
#(
  parameter  int               WIDTH   = 8,
  parameter  int               DEPTH   = 4,
  parameter  logic [WIDTH-1:0] RST_VAL = '0,
  localparam int               CW      = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t         stg [DEPTH];
  logic [DEPTH:0] en;
  logic           in_accept;

  // Ready chain: a stage may advance if it is empty or everything ahead advances.
  always_comb begin
    en        = '0;
    en[DEPTH] = out_ready & ~flush;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      en[i] = ~stg[i].valid | en[i+1];
    end
  end

  assign in_ready  = en[0] & ~flush;
  assign in_accept = in_valid & in_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             sv;
    logic [WIDTH-1:0] sd;

    if (i == 0) begin : g_head
      assign src_valid = in_accept;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = stg[i-1].valid;
      assign src_data  = stg[i-1].data;
    end

    my_pipe_stage #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk_i      (clk),
      .rst_ni     (rst),
      .clr_i      (flush),
      .en_i       (en[i]),
      .src_valid_i(src_valid),
      .src_data_i (src_data),
      .valid_o    (sv),
      .data_o     (sd)
    );

    assign stg[i] = {sv, sd};
  end

  assign out_valid = stg[DEPTH-1].valid & ~flush;
  assign out_data  = stg[DEPTH-1].data;

  // Occupancy is the number of set valid bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(stg[i].valid);
    end
  end

endmodule

// File: tb/tb_my_pipe.sv
// tb/tb_my_pipe.sv - scoreboard bench for my_pipe at DEPTH=4/WIDTH=8 and DEPTH=1/WIDTH=1
module tb_my_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv   [2];
  logic [7:0] idat [2];
  logic       ordy [2];
  logic       fl   [2];
  logic       acc  [2];

  logic       ir0, ov0;
  logic [7:0] od0;
  logic [2:0] cnt0;
  logic       ir1, ov1;
  logic [0:0] od1;
  logic [0:0] cnt1;

  int checks = 0;
  int errors = 0;

  // Reference: each held payload is a slot position (0 = input side); data order in sb queues.
  int         mn   [2];
  int         mpos [2][4];
  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];

  my_pipe #(.WIDTH(8), .DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(ordy[0]), .flush(fl[0]), .count(cnt0)
  );

  my_pipe #(.WIDTH(1), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1][0:0]), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(ordy[1]), .flush(fl[1]), .count(cnt1)
  );

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [31:0] g_ir(input int k);
    return (k == 0) ? 32'(ir0) : 32'(ir1);
  endfunction
  function automatic logic [31:0] g_ov(input int k);
    return (k == 0) ? 32'(ov0) : 32'(ov1);
  endfunction
  function automatic logic [31:0] g_od(input int k);
    return (k == 0) ? 32'(od0) : 32'(od1);
  endfunction
  function automatic logic [31:0] g_cnt(input int k);
    return (k == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  function automatic bit m_ov(input int k);
    return !fl[k] && (mn[k] > 0) && (mpos[k][0] == dep(k) - 1);
  endfunction
  function automatic bit m_ir(input int k);
    return !fl[k] && ((mn[k] < dep(k)) || ordy[k]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model update at each clock edge; async reset empties it immediately.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mn[0] = 0;
      mn[1] = 0;
      sb0.delete();
      sb1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit ov;
        bit ir;
        ov = m_ov(k);
        ir = m_ir(k);
        if (fl[k]) begin
          mn[k] = 0;
          if (k == 0) sb0.delete(); else sb1.delete();
        end else begin
          if (ov && ordy[k]) begin
            for (int i = 0; i < 3; i++) mpos[k][i] = mpos[k][i+1];
            mn[k]--;
          end
          for (int i = 0; i < mn[k]; i++) begin
            int lim;
            if (i == 0) lim = dep(k) - 1;
            else        lim = mpos[k][i-1] - 1;
            mpos[k][i] = (mpos[k][i] + 1 < lim) ? mpos[k][i] + 1 : lim;
          end
          if (iv[k] && ir) begin
            mpos[k][mn[k]] = 0;
            mn[k]++;
            if (k == 0) sb0.push_back(idat[0]);
            else        sb1.push_back(idat[1] & 8'h01);
          end
        end
      end
    end
  end

  // Monitor: compare handshake/occupancy to the model and pop released payloads.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("out_valid%0d", k), g_ov(k), 32'(m_ov(k)));
        check($sformatf("in_ready%0d", k), g_ir(k), 32'(m_ir(k)));
        check($sformatf("count%0d", k), g_cnt(k), 32'(mn[k]));
        if (g_ov(k) == 1 && ordy[k]) begin
          checks++;
          if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
            errors++;
            $display("FAIL release%0d: got payload %0h expected none", k, g_od(k));
          end else begin
            logic [7:0] e;
            e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            if (g_od(k) !== 32'(e)) begin
              errors++;
              $display("FAIL release%0d: got %0h expected %0h at %0t", k, g_od(k), e, $time);
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one payload and hold it until accepted or the budget runs out.
  task automatic send(input int k, input logic [7:0] x, input int maxw, output bit ok);
    iv[k]   = 1'b1;
    idat[k] = x;
    ok      = 1'b0;
    for (int i = 0; i < maxw; i++) begin
      @(negedge clk);
      if (g_ir(k) == 1) ok = 1'b1;
      cyc();
      if (ok) break;
    end
    iv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    ordy[k] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (g_cnt(k) == 0) break;
      cyc();
    end
    check($sformatf("drain%0d", k), g_cnt(k), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; idat[k] = '0; ordy[k] = 1'b0; fl[k] = 1'b0; acc[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid0", 32'(ov0), 0);
    check("rst_count0", 32'(cnt0), 0);
    check("rst_out_data0", 32'(od0), 0);
    check("rst_in_ready0", 32'(ir0), 1);
    check("rst_out_valid1", 32'(ov1), 0);
    check("rst_in_ready1", 32'(ir1), 1);
    rst = 1'b1;
    cyc();

    // Streaming: 0x11..0x14 back to back, out_ready high.
    ordy[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      iv[0] = 1'b1; idat[0] = 8'h11 + 8'(j);
      cyc();
    end
    iv[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("stream_valid", 32'(ov0), 1);
      check("stream_data", 32'(od0), 32'(8'h11 + 8'(j)));
      if (j == 0) check("stream_peak_count", 32'(cnt0), 4);
      cyc();
    end
    drain(0);

    // Backpressure: four fill the pipe, the fifth waits.
    ordy[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      send(0, 8'h21 + 8'(j), 1, ok);
      check("bp_accept", 32'(ok), 1);
    end
    iv[0] = 1'b1; idat[0] = 8'h25;
    @(negedge clk);
    check("bp_full_ready", 32'(ir0), 0);
    check("bp_full_count", 32'(cnt0), 4);
    cyc();
    ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_full_passthru", 32'(ir0), 1);
    check("bp_head", 32'(od0), 32'h21);
    cyc();
    iv[0] = 1'b0;
    drain(0);

    // Bubble collapse: lone payload reaches the output despite out_ready low.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; idat[0] = 8'hA5;
    cyc();
    iv[0] = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("bubble_valid", 32'(ov0), 1);
    check("bubble_data", 32'(od0), 32'hA5);
    check("bubble_ready", 32'(ir0), 1);
    cyc();
    for (int j = 0; j < 3; j++) begin
      send(0, 8'hB0 + 8'(j), 1, ok);
      check("bubble_accept", 32'(ok), 1);
    end
    @(negedge clk);
    check("bubble_full", 32'(ir0), 0);
    cyc();
    drain(0);

    // Flush with three held and a payload offered.
    ordy[0] = 1'b0;
    for (int j = 0; j < 3; j++) send(0, 8'h31 + 8'(j), 1, ok);
    cyc();
    iv[0] = 1'b1; idat[0] = 8'h5A; fl[0] = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(ir0), 0);
    check("flush_out_valid", 32'(ov0), 0);
    check("flush_pre_count", 32'(cnt0), 3);
    cyc();
    fl[0] = 1'b0;
    @(negedge clk);
    check("flush_count", 32'(cnt0), 0);
    check("flush_ready_after", 32'(ir0), 1);
    cyc();
    iv[0] = 1'b0;
    @(negedge clk);
    check("flush_accept", 32'(cnt0), 1);
    cyc();
    drain(0);

    // Asynchronous reset with two held.
    ordy[0] = 1'b0;
    for (int j = 0; j < 2; j++) send(0, 8'h41 + 8'(j), 1, ok);
    check("ar_pre_count", 32'(cnt0), 2);
    #1;
    rst = 1'b0;
    #1;
    check("ar_out_valid", 32'(ov0), 0);
    check("ar_count", 32'(cnt0), 0);
    check("ar_out_data", 32'(od0), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ordy[0] = 1'b1;
    iv[0] = 1'b1; idat[0] = 8'h61;
    cyc();
    iv[0] = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("ar_latency_valid", 32'(ov0), 1);
    check("ar_latency_data", 32'(od0), 32'h61);
    cyc();
    drain(0);

    // DEPTH=1: one-cycle latency and same-cycle accept/release.
    ordy[1] = 1'b1;
    iv[1] = 1'b1; idat[1] = 8'h01;
    cyc();
    idat[1] = 8'h00;
    @(negedge clk);
    check("d1_latency_valid", 32'(ov1), 1);
    check("d1_latency_data", 32'(od1), 1);
    check("d1_full_passthru", 32'(ir1), 1);
    check("d1_count", 32'(cnt1), 1);
    cyc();
    iv[1] = 1'b0;
    @(negedge clk);
    check("d1_second_data", 32'(od1), 0);
    cyc();
    drain(1);
    ordy[1] = 1'b0;
    iv[1] = 1'b1; idat[1] = 8'h01;
    cyc();
    idat[1] = 8'h00;
    @(negedge clk);
    check("d1_bp_ready", 32'(ir1), 0);
    check("d1_bp_count", 32'(cnt1), 1);
    cyc();
    ordy[1] = 1'b1;
    @(negedge clk);
    check("d1_same_cycle_ready", 32'(ir1), 1);
    cyc();
    iv[1] = 1'b0;
    @(negedge clk);
    check("d1_same_cycle_count", 32'(cnt1), 1);
    check("d1_same_cycle_data", 32'(od1), 0);
    cyc();
    drain(1);

    // Random traffic on both pipes; upstream holds a payload until accepted.
    for (int k = 0; k < 2; k++) acc[k] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!iv[k] || acc[k]) begin
          iv[k]   = ($urandom_range(0, 3) != 0);
          idat[k] = 8'($urandom) & ((k == 0) ? 8'hFF : 8'h01);
        end
        ordy[k] = ($urandom_range(0, 3) != 0);
        fl[k]   = ($urandom_range(0, 31) == 0);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) acc[k] = iv[k] && (g_ir(k) == 1);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (8) cyc();
    check("final_sb0_empty", 32'(sb0.size()), 0);
    check("final_sb1_empty", 32'(sb1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
